sgl_bus_bridge: RTL and testbench

- Downstream of the bypass load/store unit. Executes the single uncached/MMIO byte, half or word command that the bypass unit issues through the memory-controller single-access path.
- Performs the command on a simple valid/ready request bus with a separate response channel. Returns a one-cycle load result or store completion.
- Exactly one transaction is outstanding at a time. A timeout counter guarantees forward progress when a device never responds.

---
 rtl/sgl_bus_bridge_pkg.sv | 51 +++++
 rtl/sgl_bus_bridge_if.sv | 24 ++
 rtl/sgl_lane_align.sv | 42 ++++
 rtl/sgl_bus_bridge.sv | 144 ++++++++++++++
 tb/tb_sgl_bus_bridge.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sgl_bus_bridge_pkg.sv
// Shared types and helpers for the single-access MMIO bridge.
// Pure declarations and combinational helper functions, no latency.
// No flow control of its own.
package sgl_bus_bridge_pkg;

  typedef enum logic [2:0] {
    MEMC_NONE       = 3'd0,
    MEMC_READ_BYTE  = 3'd1,
    MEMC_READ_HALF  = 3'd2,
    MEMC_READ_WORD  = 3'd3,
    MEMC_WRITE_BYTE = 3'd4,
    MEMC_WRITE_HALF = 3'd5,
    MEMC_WRITE_WORD = 3'd6
  } memc_cmd_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  function automatic mem_size_t cmd_size(memc_cmd_t cmd);
    case (cmd)
      MEMC_READ_BYTE, MEMC_WRITE_BYTE: return BYTE;
      MEMC_READ_HALF, MEMC_WRITE_HALF: return HALF;
      default:                         return WORD;
    endcase
  endfunction

  function automatic logic cmd_is_write(memc_cmd_t cmd);
    return (cmd == MEMC_WRITE_BYTE) || (cmd == MEMC_WRITE_HALF) ||
           (cmd == MEMC_WRITE_WORD);
  endfunction

  // Byte strobes for an access of the given size starting at lane off.
  function automatic logic [3:0] gen_strb(mem_size_t size, logic [1:0] off);
    case (size)
      BYTE:    return 4'b0001 << off;
      HALF:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sgl_bus_bridge_if.sv
// Device-side request/response bus: valid/ready request plus response channel.
// Wires only, no latency.
// Request side stalls on req_ready; the response channel is always accepted.
interface sgl_bus_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_strb,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_strb,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/sgl_lane_align.sv
// Lane handling: write strobes, misalignment detection, read shift and mask.
// Purely combinational, zero latency.
// No flow control.
module sgl_lane_align
  import sgl_bus_bridge_pkg::*;
(
  input  mem_size_t   acc_size,
  input  logic [1:0]  acc_off,
  output logic [3:0]  acc_strb,
  output logic        acc_misaligned,
  input  mem_size_t   rd_size,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_data
);

  logic [31:0] shifted;

  assign acc_strb = gen_strb(acc_size, acc_off);
  assign shifted  = rd_word >> {rd_off, 3'b000};

  // Halves must sit on even lanes and words on lane 0.
  always_comb begin
    acc_misaligned = 1'b0;
    case (acc_size)
      HALF:    acc_misaligned = acc_off[0];
      WORD:    acc_misaligned = (acc_off != 2'b00);
      default: acc_misaligned = 1'b0;
    endcase
  end

  // Right-align the addressed lanes and zero everything above the access size.
  always_comb begin
    rd_data = shifted;
    case (rd_size)
      BYTE:    rd_data = {24'h0, shifted[7:0]};
      HALF:    rd_data = {16'h0, shifted[15:0]};
      default: rd_data = shifted;
    endcase
  end

endmodule

// File: rtl/sgl_bus_bridge.sv
// Runs one uncached byte/half/word command on the device bus, one in flight.
// Zero-wait bus: accept at cycle 0, request cycle 1, response cycle 2, result cycle 3.
// OUT_stall holds the source while busy; request waits on req_ready; timeout aborts.
module sgl_bus_bridge
  import sgl_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  memc_cmd_t        IN_cmd,
  input  logic [31:0]      IN_addr,
  input  logic [31:0]      IN_wdata,
  output logic             OUT_stall,
  output logic             OUT_ldValid,
  output logic [31:0]      OUT_ldData,
  output logic             OUT_stValid,
  output logic             OUT_err,
  sgl_bus_bridge_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  bridge_state_t    state;
  bridge_state_t    state_nxt;
  memc_cmd_t        cmd_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       strb_q;
  logic             err_q;
  logic [31:0]      ld_data_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic             accept;
  logic             tmo_hit;
  logic             wr_q;
  mem_size_t        in_size;
  mem_size_t        q_size;
  logic [3:0]       in_strb;
  logic             in_misaligned;
  logic [31:0]      rd_aligned;

  assign accept  = (state == ST_IDLE) && (IN_cmd != MEMC_NONE);
  assign in_size = cmd_size(IN_cmd);
  assign q_size  = cmd_size(cmd_q);
  assign wr_q    = cmd_is_write(cmd_q);

  // Expiry cycle: the counter reaches TIMEOUT_CYCLES-1 on this edge.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   ((32'(tmo_cnt) + 32'd1) >= (TIMEOUT_CYCLES - 32'd1));

  sgl_lane_align u_align (
    .acc_size       (in_size),
    .acc_off        (IN_addr[1:0]),
    .acc_strb       (in_strb),
    .acc_misaligned (in_misaligned),
    .rd_size        (q_size),
    .rd_off         (addr_q[1:0]),
    .rd_word        (bus.rsp_data),
    .rd_data        (rd_aligned)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Sequencing; a handshake beats expiry in REQ, a response beats expiry in RSP.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = in_misaligned ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (bus.req_ready)  state_nxt = ST_RSP;
        else if (tmo_hit)   state_nxt = ST_DONE;
      end
      ST_RSP:  if (bus.rsp_valid || tmo_hit) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command capture, timeout counting and result/error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= MEMC_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q   <= IN_cmd;
            addr_q  <= IN_addr;
            wdata_q <= IN_wdata;
            strb_q  <= in_strb;
            err_q   <= in_misaligned;
            tmo_cnt <= '0;
            if (in_misaligned && !cmd_is_write(IN_cmd)) ld_data_q <= ERR_RDATA;
          end
        end
        ST_REQ: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (!bus.req_ready && tmo_hit) begin
            err_q <= 1'b1;
            if (!wr_q) ld_data_q <= ERR_RDATA;
          end
        end
        ST_RSP: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (bus.rsp_valid) begin
            err_q <= bus.rsp_err;
            if (!wr_q) ld_data_q <= bus.rsp_err ? ERR_RDATA : rd_aligned;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            if (!wr_q) ld_data_q <= ERR_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // State-decoded outputs; completion pulses live only in DONE.
  always_comb begin
    OUT_stall     = (state != ST_IDLE);
    bus.req_valid = (state == ST_REQ);
    OUT_ldValid   = (state == ST_DONE) && !wr_q;
    OUT_stValid   = (state == ST_DONE) && wr_q;
    OUT_err       = (state == ST_DONE) && err_q;
  end

  assign bus.req_we    = wr_q;
  assign bus.req_addr  = {addr_q[31:2], 2'b00};
  assign bus.req_wdata = wdata_q;
  assign bus.req_strb  = wr_q ? strb_q : 4'b0000;
  assign OUT_ldData    = ld_data_q;

endmodule

// File: tb/tb_sgl_bus_bridge.sv
// Randomized and directed bench for sgl_bus_bridge against a transaction model.
// Expected latency, strobes, data and error derived per transaction.
// Bench plays the bus device with configurable ready and response delays.
module tb_sgl_bus_bridge;
  import sgl_bus_bridge_pkg::*;

  localparam int          TMO   = 8;
  localparam logic [31:0] ERR_D = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  memc_cmd_t   in_cmd;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        st_valid;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_ld = 32'h0;

  sgl_bus_bridge_if bus ();

  sgl_bus_bridge #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR_D)) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_cmd      (in_cmd),
    .IN_addr     (in_addr),
    .IN_wdata    (in_wdata),
    .OUT_stall   (stall),
    .OUT_ldValid (ld_valid),
    .OUT_ldData  (ld_data),
    .OUT_stValid (st_valid),
    .OUT_err     (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("gap_quiet", 32'({stall, ld_valid, st_valid, bus.req_valid}), 32'h0);
    end
  endtask

  task automatic stray_rsp(input int n_cyc);
    int hits;
    hits = 0;
    @(negedge clk);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = $urandom;
    bus.rsp_err   = 1'b0;
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      if (ld_valid || st_valid || stall || bus.req_valid) hits++;
    end
    check_eq("stray_ignored", 32'(hits), 32'h0);
    check_eq("stray_ld_hold", ld_data, model_ld);
  endtask

  // One command: model the expected outcome, play the device, then compare.
  task automatic run_txn(input memc_cmd_t cmd, input logic [31:0] addr, input logic [31:0] wdata,
                         input int rdy_dly, input int rsp_dly, input bit no_rdy, input bit no_rsp,
                         input logic [31:0] rsp_word, input bit rsp_err, input bit hold);
    int          n, off, e_lat, e_req;
    bit          wr, mis, tmo, e_err, got_pulse;
    logic [3:0]  e_strb;
    logic [31:0] e_ld, mask;
    int          rsp_cyc, pulse_cyc, req_cyc, unstable, stall_low;
    logic [31:0] s_addr, s_wdata, s_ld;
    logic [3:0]  s_strb;
    logic        s_we, s_err;
    logic [1:0]  s_kind;

    n    = (cmd == MEMC_READ_BYTE || cmd == MEMC_WRITE_BYTE) ? 1 :
           (cmd == MEMC_READ_HALF || cmd == MEMC_WRITE_HALF) ? 2 : 4;
    wr   = (cmd >= MEMC_WRITE_BYTE);
    off  = int'(addr % 32'd4);
    mis  = (off % n) != 0;
    tmo  = !mis && (no_rdy || no_rsp);
    e_strb = wr ? 4'(((1 << n) - 1) << off) : 4'h0;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    if (mis)      begin e_err = 1'b1; e_lat = 1;   e_req = 0; end
    else if (tmo) begin e_err = 1'b1; e_lat = TMO; e_req = no_rdy ? TMO - 1 : rdy_dly + 1; end
    else          begin e_err = rsp_err; e_lat = rdy_dly + rsp_dly + 3; e_req = rdy_dly + 1; end
    e_ld = e_err ? ERR_D : ((rsp_word >> (8 * off)) & mask);

    rsp_cyc = -1; pulse_cyc = -1; req_cyc = 0; unstable = 0; stall_low = 0; got_pulse = 1'b0;
    s_addr = '0; s_wdata = '0; s_strb = '0; s_we = 1'b0; s_err = 1'b0; s_ld = '0; s_kind = '0;

    @(negedge clk);
    check_eq("accept_stall", 32'(stall), 32'h0);
    check_eq("accept_quiet", 32'({ld_valid, st_valid}), 32'h0);
    in_cmd = cmd; in_addr = addr; in_wdata = wdata;

    for (int cyc = 1; cyc <= 40 && !got_pulse; cyc++) begin
      @(negedge clk);
      if (!hold) in_cmd = MEMC_NONE;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      if (!stall) stall_low++;
      if (ld_valid || st_valid) begin
        got_pulse = 1'b1; pulse_cyc = cyc;
        s_kind = {ld_valid, st_valid}; s_err = err; s_ld = ld_data;
      end else if (bus.req_valid) begin
        if (req_cyc == 0) begin
          s_addr = bus.req_addr; s_wdata = bus.req_wdata; s_strb = bus.req_strb; s_we = bus.req_we;
        end else if ({bus.req_addr, bus.req_wdata, bus.req_strb, bus.req_we} !==
                     {s_addr, s_wdata, s_strb, s_we}) begin
          unstable++;
        end
        req_cyc++;
        if (!no_rdy && cyc >= 1 + rdy_dly) begin
          bus.req_ready = 1'b1;
          if (!no_rsp) rsp_cyc = cyc + 1 + rsp_dly;
        end
      end
      if (cyc == rsp_cyc) begin
        bus.rsp_valid = 1'b1; bus.rsp_data = rsp_word; bus.rsp_err = rsp_err;
      end
    end

    check_eq("pulse_seen", 32'(got_pulse), 32'h1);
    if (got_pulse) begin
      check_eq("latency", 32'(pulse_cyc), 32'(e_lat));
      check_eq("pulse_kind", 32'(s_kind), wr ? 32'h1 : 32'h2);
      check_eq("err", 32'(s_err), 32'(e_err));
      if (!wr) model_ld = e_ld;
      check_eq("ld_data", s_ld, model_ld);
      check_eq("stall_busy", 32'(stall_low), 32'h0);
    end
    check_eq("req_cycles", 32'(req_cyc), 32'(e_req));
    if (req_cyc > 0) begin
      check_eq("req_addr", s_addr, addr & ~32'h3);
      check_eq("req_we", 32'(s_we), 32'(wr));
      check_eq("req_strb", 32'(s_strb), 32'(e_strb));
      if (wr) check_eq("req_wdata", s_wdata, wdata);
      check_eq("req_stable", 32'(unstable), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    memc_cmd_t   c;
    logic [31:0] a, w, d;
    rst = 1'b1; in_cmd = MEMC_NONE; in_addr = '0; in_wdata = '0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.rsp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'h0);
    check_eq("rst_req_valid", 32'(bus.req_valid), 32'h0);
    check_eq("rst_pulses", 32'({ld_valid, st_valid, err}), 32'h0);
    check_eq("rst_ld_data", ld_data, 32'h0);
    rst = 1'b0;

    // Zero-wait byte read from the top lane.
    run_txn(MEMC_READ_BYTE, 32'h1000_0003, 32'h0, 0, 0, 0, 0, 32'hAABB_CCDD, 0, 0);
    // Half write held off by the device for five cycles.
    run_txn(MEMC_WRITE_HALF, 32'h2000_0002, 32'h1234_0000, 5, 0, 0, 0, 32'h0, 0, 0);
    // Misaligned word read.
    run_txn(MEMC_READ_WORD, 32'h2000_0001, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    // Timeout in the response phase, a late response, then a normal read.
    run_txn(MEMC_READ_WORD, 32'h4000_0000, 32'h0, 0, 0, 0, 1, 32'h0, 0, 0);
    stray_rsp(3);
    run_txn(MEMC_READ_HALF, 32'h4000_0002, 32'h0, 1, 1, 0, 0, 32'h5566_7788, 0, 0);
    // Timeout in the request phase.
    run_txn(MEMC_WRITE_WORD, 32'h4000_0010, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'h0, 0, 0);
    // Back-to-back with the command held through the first transaction.
    run_txn(MEMC_WRITE_BYTE, 32'h5000_0001, 32'h0000_AB00, 1, 1, 0, 0, 32'h0, 0, 1);
    run_txn(MEMC_READ_BYTE, 32'h5000_0001, 32'h0, 0, 2, 0, 0, 32'h0000_AB00, 0, 0);
    // Device error on a load.
    run_txn(MEMC_READ_WORD, 32'h6000_0000, 32'h0, 0, 0, 0, 0, 32'h1111_2222, 1, 0);

    // Reset while waiting for a response.
    @(negedge clk);
    in_cmd = MEMC_READ_WORD; in_addr = 32'h3000_0000;
    @(negedge clk);
    in_cmd = MEMC_NONE;
    check_eq("rstmid_req", 32'(bus.req_valid), 32'h1);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstmid_state", 32'({stall, bus.req_valid, ld_valid, st_valid, err}), 32'h0);
    check_eq("rstmid_ld_data", ld_data, 32'h0);
    model_ld = 32'h0;
    stray_rsp(4);

    for (int t = 0; t < 40; t++) begin
      c = memc_cmd_t'($urandom_range(1, 6));
      a = $urandom; w = $urandom; d = $urandom;
      run_txn(c, a, w, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0),
              d, ($urandom_range(0, 3) == 0), 0);
      idle_gap(int'($urandom_range(0, 2)));
    end
    idle_gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
